// File: rtl/seg_bcd_display.sv
// seg_bcd_display: serial double-dabble converter driving DIGITS seven-segment displays
module seg_bcd_display #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      operand,
    input  logic                  mode,
    input  logic                  blank_en,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   display
);
    localparam int NB = (WIDTH + 4) / 3 + 1;
    localparam int BW = 4 * NB;
    localparam int NX = NB > DIGITS ? NB : DIGITS;
    localparam int OX = WIDTH > DIGITS ? WIDTH : DIGITS;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    opr_q, opr_d, orig_q;
    logic [BW-1:0]       bcd_q, bcd_d, adj;
    logic [4:0]          cnt_q;
    logic                mode_q, blank_q, done_q, ovf_q, ovf_d, lead;
    logic [7*DIGITS-1:0] disp_q, disp_d;
    logic [4*NX-1:0]     dx;
    logic [OX-1:0]       ox;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next state: one SHIFT per operand bit, then a single LOAD cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SHIFT : IDLE;
            SHIFT:   state_d = (cnt_q == 5'd1) ? LOAD : SHIFT;
            default: state_d = IDLE;
        endcase
    end

    // outputs: busy is a pure decode of the registered state
    always_comb begin
        busy     = state_q != IDLE;
        done     = done_q;
        overflow = ovf_q;
        display  = disp_q;
    end

    // datapath: latch on accepted start, shift during SHIFT, publish on LOAD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opr_q   <= '0;
            orig_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            blank_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            disp_q  <= '1;
        end else begin
            done_q <= state_q == LOAD;
            if (state_q == IDLE && start) begin
                opr_q   <= operand;
                orig_q  <= operand;
                mode_q  <= mode;
                blank_q <= blank_en;
                bcd_q   <= '0;
                cnt_q   <= 5'(WIDTH);
            end else if (state_q == SHIFT) begin
                opr_q <= opr_d;
                bcd_q <= bcd_d;
                cnt_q <= cnt_q - 5'd1;
            end
            if (state_q == LOAD) begin
                disp_q <= disp_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    // one double-dabble step: add 3 to nibbles >= 5, then shift the whole chain left
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NB; i++)
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        {bcd_d, opr_d} = {adj, opr_q} << 1;
    end

    // display encoding from the finished BCD value or the original operand bits
    always_comb begin
        dx = '0;
        dx[BW-1:0] = bcd_q;
        ox = '0;
        ox[WIDTH-1:0] = orig_q;
        disp_d = '1;
        ovf_d = 1'b0;
        lead = 1'b1;
        if (mode_q) begin
            ovf_d = WIDTH > DIGITS;
            for (int i = 0; i < DIGITS; i++)
                if (i < WIDTH) disp_d[7*i +: 7] = seg7({3'b000, ox[i]});
        end else begin
            for (int i = 0; i < NX; i++)
                if (i >= DIGITS && dx[4*i +: 4] != 4'd0) ovf_d = 1'b1;
            for (int i = DIGITS - 1; i >= 0; i--) begin
                if (dx[4*i +: 4] != 4'd0) lead = 1'b0;
                disp_d[7*i +: 7] = ovf_d ? DASH : (blank_q && lead && i != 0) ? BLANK : seg7(dx[4*i +: 4]);
            end
        end
    end
endmodule

// File: tb/tb_seg_bcd_display.sv
// tb_seg_bcd_display: scoreboard bench for two display driver configurations
module tb_seg_bcd_display;
    logic clk = 1'b0, reset = 1'b1;
    logic start1 = 1'b0, mode1 = 1'b0, blank1 = 1'b0;
    logic [5:0] op1 = '0;
    logic busy1, done1, ovf1;
    logic [41:0] disp1;
    logic start2 = 1'b0, mode2 = 1'b0, blank2 = 1'b0;
    logic [7:0] op2 = '0;
    logic busy2, done2, ovf2;
    logic [13:0] disp2;
    int n_chk = 0, n_pass = 0, cyc = 0;

    typedef struct {
        logic [55:0] disp;
        logic        ovf;
        int          due;
    } exp_t;
    exp_t q1[$], q2[$];

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    seg_bcd_display #(.WIDTH(6), .DIGITS(6)) u_dut (
        .clk(clk), .reset(reset), .start(start1), .operand(op1), .mode(mode1), .blank_en(blank1),
        .busy(busy1), .done(done1), .overflow(ovf1), .display(disp1)
    );

    seg_bcd_display #(.WIDTH(8), .DIGITS(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .operand(op2), .mode(mode2), .blank_en(blank2),
        .busy(busy2), .done(done2), .overflow(ovf2), .display(disp2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input int v, input bit m, input bit b, input int w, input int d, input int due);
        exp_t e;
        int p = 1, pw = 1, msd = 0;
        e.disp = '1;
        e.ovf = 1'b0;
        e.due = due;
        if (m) begin
            e.ovf = w > d;
            for (int k = 0; k < d; k++)
                if (k < w) e.disp[7*k +: 7] = seg_tab[(v >> k) & 1];
        end else begin
            for (int k = 0; k < d; k++) begin
                if ((v / p) % 10 != 0) msd = k;
                p *= 10;
            end
            e.ovf = v >= p;
            for (int k = 0; k < d; k++) begin
                e.disp[7*k +: 7] = e.ovf ? 7'b0111111 : (b && k > msd) ? 7'b1111111 : seg_tab[(v / pw) % 10];
                pw *= 10;
            end
        end
        return e;
    endfunction

    task automatic go(input int u, input int v, input bit m, input bit b, input bit push);
        @(negedge clk);
        if (u == 1) begin
            op1 = 6'(v); mode1 = m; blank1 = b; start1 = 1'b1;
            if (push) q1.push_back(model(v, m, b, 6, 6, cyc + 8));
        end else begin
            op2 = 8'(v); mode2 = m; blank2 = b; start2 = 1'b1;
            if (push) q2.push_back(model(v, m, b, 8, 2, cyc + 10));
        end
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        check(u == 1 ? "busy1 after start" : "busy2 after start", u == 1 ? busy1 : busy2, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done1) begin
            if (q1.size() == 0) check("done1 unexpected", 1, 0);
            else begin
                e = q1.pop_front();
                check("disp1", disp1, e.disp[41:0]);
                check("ovf1", ovf1, e.ovf);
                check("latency1", cyc, e.due);
                check("busy1 at done", busy1, 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done2) begin
            if (q2.size() == 0) check("done2 unexpected", 1, 0);
            else begin
                e = q2.pop_front();
                check("disp2", disp2, e.disp[13:0]);
                check("ovf2", ovf2, e.ovf);
                check("latency2", cyc, e.due);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset busy1", busy1, 0);
        check("reset done1", done1, 0);
        check("reset ovf1", ovf1, 0);
        check("reset disp1", disp1, {42{1'b1}});
        check("reset disp2", disp2, {14{1'b1}});
        reset = 1'b0;
        go(1, 20, 0, 1, 1);
        repeat (8) @(negedge clk);
        check("dec20 digit0", disp1[6:0], 7'b1000000);
        check("dec20 digit1", disp1[13:7], 7'b0100100);
        check("dec20 upper blank", disp1[41:14], {28{1'b1}});
        go(1, 20, 1, 0, 1);
        repeat (8) @(negedge clk);
        go(1, 0, 0, 1, 1);
        repeat (8) @(negedge clk);
        go(1, 9, 0, 0, 1);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            go(1, int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
            repeat (8) @(negedge clk);
        end
        go(2, 255, 0, 1, 1);
        repeat (10) @(negedge clk);
        go(2, 0, 0, 1, 1);
        repeat (10) @(negedge clk);
        go(2, 99, 0, 1, 1);
        repeat (10) @(negedge clk);
        go(2, 100, 0, 0, 1);
        repeat (10) @(negedge clk);
        go(2, 13, 1, 0, 1);
        repeat (10) @(negedge clk);
        go(1, 5, 0, 1, 1);
        repeat (1) @(negedge clk);
        go(1, 60, 0, 1, 0);
        repeat (8) @(negedge clk);
        go(1, 37, 0, 1, 1);
        repeat (6) @(negedge clk);
        go(1, 12, 0, 0, 1);
        repeat (8) @(negedge clk);
        go(1, 20, 0, 1, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async rst busy1", busy1, 0);
        check("async rst done1", done1, 0);
        check("async rst ovf2", ovf2, 0);
        check("async rst disp1", disp1, {42{1'b1}});
        check("async rst disp2", disp2, {14{1'b1}});
        q1.delete();
        q2.delete();
        @(negedge clk);
        reset = 1'b0;
        go(1, 63, 0, 0, 1);
        repeat (8) @(negedge clk);
        check("dec 000063", disp1, {{4{7'b1000000}}, 7'b0000010, 7'b0110000});
        repeat (4) @(negedge clk);
        check("q1 drained", q1.size(), 0);
        check("q2 drained", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
